sha256_msg_padder: RTL

// - Upstream feeder of the SHA-256 core in the Hash160 path: takes a byte message as a stream of 32-bit big-endian words.
// - Applies FIPS 180-4 padding: 0x80 terminator, zero fill, 64-bit bit-length field.
// - Emits complete 512-bit blocks over a valid/ready handshake, with first/last-block flags for the core sequencer.

---
 rtl/sha256_msg_padder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a stream of 32-bit big-endian words into padded
// 512-bit blocks (0x80 terminator, zero fill, 64-bit bit length) for the core.
module sha256_msg_padder #(
   parameter int unsigned LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   input  logic [2:0]   s_nbytes,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [511:0] m_block,
   output logic         m_first,
   output logic         m_last,
   output logic         busy
);

   localparam int unsigned WORDS = 16;

   typedef enum logic [1:0] {FILL, EMIT, EMIT_PRE, EXTRA} state_t;

   state_t                      state;
   logic [3:0]                  widx;
   logic [LEN_W-1:0]            bitlen;
   logic [WORDS-1:0][31:0]      blk;
   logic                        first_pend;
   logic                        pad_pend;

   logic [2:0]                  nb;
   logic [31:0]                 wdata;
   logic [3:0]                  widx_p1;
   logic [6:0]                  offs;
   logic [LEN_W-1:0]            bitlen_nxt;
   logic [63:0]                 len_field;
   logic                        fits;
   logic                        full_blk;
   logic [WORDS-1:0][31:0]      fill_blk;

   assign s_ready = (state == FILL);

   // Beat decode: byte count, masked word with terminator, and resulting block image
   always_comb begin
      nb = 3'd4;
      if (s_last && (s_nbytes < 3'd4)) nb = s_nbytes;

      wdata = '0;
      for (int b = 0; b < 4; b++) begin
         if (3'(b) < nb)
            wdata[31-8*b -: 8] = s_data[31-8*b -: 8];
         else if ((3'(b) == nb) && s_last)
            wdata[31-8*b -: 8] = 8'h80;
      end

      widx_p1    = widx + 4'd1;
      offs       = 7'({widx, 2'b00}) + 7'(nb);
      bitlen_nxt = bitlen + (LEN_W'(nb) << 3);
      len_field  = 64'(bitlen_nxt);
      fits       = (offs <= 7'd55);
      full_blk   = s_last && (offs == 7'd64);

      fill_blk         = blk;
      fill_blk[~widx]  = wdata;
      // A full final word leaves the terminator for the next word slot, if any
      if (s_last && (nb == 3'd4) && (widx != 4'd15))
         fill_blk[~widx_p1] = 32'h8000_0000;
      if (s_last && fits) begin
         fill_blk[1] = len_field[63:32];
         fill_blk[0] = len_field[31:0];
      end
   end

   // Control FSM with registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         widx       <= '0;
         bitlen     <= '0;
         blk        <= '0;
         first_pend <= 1'b1;
         pad_pend   <= 1'b0;
         m_valid    <= 1'b0;
         m_block    <= '0;
         m_first    <= 1'b0;
         m_last     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (s_valid) begin
                  blk    <= fill_blk;
                  widx   <= widx_p1;
                  bitlen <= bitlen_nxt;
                  busy   <= 1'b1;
                  if (s_last || (widx == 4'd15)) begin
                     m_block <= fill_blk;
                     m_valid <= 1'b1;
                     m_first <= first_pend;
                  end
                  if (s_last) begin
                     if (fits) begin
                        m_last <= 1'b1;
                        state  <= EMIT;
                     end else begin
                        m_last   <= 1'b0;
                        pad_pend <= full_blk;
                        state    <= EMIT_PRE;
                     end
                  end else if (widx == 4'd15) begin
                     m_last <= 1'b0;
                     state  <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (m_ready) begin
                  m_valid    <= 1'b0;
                  m_first    <= 1'b0;
                  m_last     <= 1'b0;
                  blk        <= '0;
                  widx       <= '0;
                  first_pend <= 1'b0;
                  if (m_last) begin
                     bitlen     <= '0;
                     first_pend <= 1'b1;
                     busy       <= 1'b0;
                  end
                  state <= FILL;
               end
            end
            EMIT_PRE: begin
               if (m_ready) begin
                  blk        <= '0;
                  widx       <= '0;
                  first_pend <= 1'b0;
                  m_block    <= {(pad_pend ? 32'h8000_0000 : 32'h0), 416'b0, 64'(bitlen)};
                  m_first    <= 1'b0;
                  m_last     <= 1'b1;
                  state      <= EXTRA;
               end
            end
            EXTRA: begin
               if (m_ready) begin
                  m_valid    <= 1'b0;
                  m_last     <= 1'b0;
                  bitlen     <= '0;
                  first_pend <= 1'b1;
                  pad_pend   <= 1'b0;
                  busy       <= 1'b0;
                  state      <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
